// File: rtl/mem_requester_if.sv
// Bundle of command, memory-side and response signals for mem_requester.
// master: the requester itself (drives cmd_ready, memory strobes, responses, status).
// slave : the client/memory environment (drives commands and returns).
interface mem_requester_if #(
  parameter int DEPTH = 4
) ();
  // client command channel
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [15:0]                  cmd_address;
  logic [15:0]                  cmd_data;
  // memory-side write request and return
  logic [15:0]                  wr_address;
  logic [15:0]                  wr_data;
  logic                         wr_en;
  logic [15:0]                  wr_ret_address;
  logic                         wr_ret_ack;
  // memory-side read request and return
  logic [15:0]                  rd_address;
  logic                         rd_en;
  logic [15:0]                  rd_ret_address;
  logic [15:0]                  rd_ret_data;
  logic                         rd_ret_ack;
  // completions to the client
  logic                         rd_resp_valid;
  logic [15:0]                  rd_resp_address;
  logic [15:0]                  rd_resp_data;
  logic                         wr_resp_valid;
  logic [15:0]                  wr_resp_address;
  // status
  logic [$clog2(DEPTH+1)-1:0]   outstanding;
  logic                         err_unexpected;
  logic                         err_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_data,
    input  wr_ret_address, wr_ret_ack,
    input  rd_ret_address, rd_ret_data, rd_ret_ack,
    output cmd_ready,
    output wr_address, wr_data, wr_en,
    output rd_address, rd_en,
    output rd_resp_valid, rd_resp_address, rd_resp_data,
    output wr_resp_valid, wr_resp_address,
    output outstanding, err_unexpected, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_data,
    output wr_ret_address, wr_ret_ack,
    output rd_ret_address, rd_ret_data, rd_ret_ack,
    input  cmd_ready,
    input  wr_address, wr_data, wr_en,
    input  rd_address, rd_en,
    input  rd_resp_valid, rd_resp_address, rd_resp_data,
    input  wr_resp_valid, wr_resp_address,
    input  outstanding, err_unexpected, err_timeout
  );
endinterface

// File: rtl/mem_requester.sv
// Tracks outstanding memory requests by address tag, matches returns, ages out lost ones.
// Latency: 1 cycle accept->rd_en/wr_en strobe; 1 cycle return->client response.
// Backpressure: cmd_ready drops when the table is full or cmd_address is already in flight.
// Ports: clk, rst_n (sync, active low); bus (mem_requester_if.master) carries the command
//   channel, memory-side request/return strobes, client responses, outstanding count and
//   sticky err_unexpected / err_timeout flags.
module mem_requester #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 200,
  parameter int WR_ACK_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_requester_if.master  bus
);

  localparam int         CW        = $clog2(DEPTH + 1);
  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         TRACK_WR  = (WR_ACK_EN != 0);
  // An entry whose age already equals TIMEOUT-1 would reach TIMEOUT on this edge.
  localparam logic [7:0] AGE_LIMIT = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [15:0] address;
    logic [7:0]  age;
  } entry_t;

  entry_t           tbl_q [DEPTH];
  logic             run_q;          // low for the first cycle after reset release

  logic [DEPTH-1:0] hit_cmd;
  logic [DEPTH-1:0] hit_rd;
  logic [DEPTH-1:0] hit_wr;
  logic [DEPTH-1:0] expire;
  logic [DEPTH-1:0] ret_free;
  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic             accept;
  logic             alloc;
  logic             rd_ok;
  logic             wr_ok;
  logic             unexp_rd;
  logic             unexp_wr;
  logic [CW-1:0]    valid_cnt;

  // Table lookups. Tags are unique in the table, so at most one entry hits each port.
  // The descending scan leaves free_idx at the lowest free index.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_cmd  = '0;
    hit_rd   = '0;
    hit_wr   = '0;
    expire   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      hit_cmd[i] = tbl_q[i].valid && (tbl_q[i].address == bus.cmd_address);
      hit_rd[i]  = tbl_q[i].valid && !tbl_q[i].is_write && bus.rd_ret_ack &&
                   (tbl_q[i].address == bus.rd_ret_address);
      hit_wr[i]  = TRACK_WR && tbl_q[i].valid && tbl_q[i].is_write && bus.wr_ret_ack &&
                   (tbl_q[i].address == bus.wr_ret_address);
      expire[i]  = tbl_q[i].valid && (tbl_q[i].age >= AGE_LIMIT);
    end
  end

  // A return racing its own timeout loses: the entry is treated as timed out and the
  // return counts as unexpected.
  always_comb begin
    ret_free = (hit_rd | hit_wr) & ~expire;
    rd_ok    = |(hit_rd & ~expire);
    wr_ok    = |(hit_wr & ~expire);
    unexp_rd = bus.rd_ret_ack && !rd_ok;
    unexp_wr = TRACK_WR && bus.wr_ret_ack && !wr_ok;
  end

  // Ready looks only at registered table state, so an entry freed this cycle becomes
  // allocatable on the next one.
  always_comb begin
    bus.cmd_ready = run_q && free_any && !(|hit_cmd);
    accept        = bus.cmd_valid && bus.cmd_ready;
    alloc         = accept && (!bus.cmd_write || TRACK_WR);
  end

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt = valid_cnt + CW'(tbl_q[i].valid);
    end
    bus.outstanding = valid_cnt;
  end

  // Entry table: free on timeout or matching return, else age; allocate into the
  // selected free slot. A slot being freed is still valid here, so it is never reused
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (tbl_q[i].valid) begin
          if (expire[i] || ret_free[i]) begin
            tbl_q[i].valid <= 1'b0;
          end else if (tbl_q[i].age != 8'hFF) begin
            tbl_q[i].age <= tbl_q[i].age + 8'd1;
          end
        end else if (alloc && (free_idx == IW'(i))) begin
          tbl_q[i].valid    <= 1'b1;
          tbl_q[i].is_write <= bus.cmd_write;
          tbl_q[i].address  <= bus.cmd_address;
          tbl_q[i].age      <= 8'd0;
        end
      end
    end
  end

  // Memory-side request strobes, one cycle after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_en      <= 1'b0;
      bus.rd_address <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_address <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.rd_en <= accept && !bus.cmd_write;
      bus.wr_en <= accept && bus.cmd_write;
      if (accept && !bus.cmd_write) begin
        bus.rd_address <= bus.cmd_address;
      end
      if (accept && bus.cmd_write) begin
        bus.wr_address <= bus.cmd_address;
        bus.wr_data    <= bus.cmd_data;
      end
    end
  end

  // Client completions and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_resp_valid   <= 1'b0;
      bus.rd_resp_address <= '0;
      bus.rd_resp_data    <= '0;
      bus.wr_resp_valid   <= 1'b0;
      bus.wr_resp_address <= '0;
      bus.err_unexpected  <= 1'b0;
      bus.err_timeout     <= 1'b0;
    end else begin
      bus.rd_resp_valid <= rd_ok;
      if (rd_ok) begin
        bus.rd_resp_address <= bus.rd_ret_address;
        bus.rd_resp_data    <= bus.rd_ret_data;
      end
      if (TRACK_WR) begin
        bus.wr_resp_valid <= wr_ok;
        if (wr_ok) begin
          bus.wr_resp_address <= bus.wr_ret_address;
        end
      end else begin
        // Posted writes complete to the client alongside the wr_en strobe.
        bus.wr_resp_valid <= accept && bus.cmd_write;
        if (accept && bus.cmd_write) begin
          bus.wr_resp_address <= bus.cmd_address;
        end
      end
      bus.err_unexpected <= bus.err_unexpected | unexp_rd | unexp_wr;
      bus.err_timeout    <= bus.err_timeout | (|expire);
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: two instances (posted writes / tracked writes with
// a short timeout); client responses are checked against a scoreboard of expected
// {address,data} pairs pushed when the matching stimulus is driven.
module tb_mem_requester;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] qa_rd[$];
  logic [31:0] qa_wr[$];
  logic [31:0] qb_rd[$];
  logic [31:0] qb_wr[$];

  mem_requester_if #(.DEPTH(4)) ia ();
  mem_requester_if #(.DEPTH(2)) ib ();

  mem_requester #(.DEPTH(4), .TIMEOUT(200), .WR_ACK_EN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  mem_requester #(.DEPTH(2), .TIMEOUT(5), .WR_ACK_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic a_cmd(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    ia.cmd_valid = v; ia.cmd_write = w; ia.cmd_address = a; ia.cmd_data = d;
  endtask

  task automatic b_cmd(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    ib.cmd_valid = v; ib.cmd_write = w; ib.cmd_address = a; ib.cmd_data = d;
  endtask

  task automatic a_rret(input logic v, input logic [15:0] a, input logic [15:0] d);
    ia.rd_ret_ack = v; ia.rd_ret_address = a; ia.rd_ret_data = d;
    if (v) qa_rd.push_back({a, d});
  endtask

  // Response monitor: every completion must match the oldest expected entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (ia.rd_resp_valid === 1'b1) begin
      if (qa_rd.size() == 0) chk("a_rd_resp_unexpected", 32'd1, 32'd0);
      else begin e = qa_rd.pop_front(); chk("a_rd_resp", {ia.rd_resp_address, ia.rd_resp_data}, e); end
    end
    if (ia.wr_resp_valid === 1'b1) begin
      if (qa_wr.size() == 0) chk("a_wr_resp_unexpected", 32'd1, 32'd0);
      else begin e = qa_wr.pop_front(); chk("a_wr_resp", {ia.wr_resp_address, 16'h0}, e); end
    end
    if (ib.rd_resp_valid === 1'b1) begin
      if (qb_rd.size() == 0) chk("b_rd_resp_unexpected", 32'd1, 32'd0);
      else begin e = qb_rd.pop_front(); chk("b_rd_resp", {ib.rd_resp_address, ib.rd_resp_data}, e); end
    end
    if (ib.wr_resp_valid === 1'b1) begin
      if (qb_wr.size() == 0) chk("b_wr_resp_unexpected", 32'd1, 32'd0);
      else begin e = qb_wr.pop_front(); chk("b_wr_resp", {ib.wr_resp_address, 16'h0}, e); end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_cmd(0, 0, 16'h0, 16'h0);
    b_cmd(0, 0, 16'h0, 16'h0);
    ia.rd_ret_ack = 0; ia.rd_ret_address = 0; ia.rd_ret_data = 0;
    ia.wr_ret_ack = 0; ia.wr_ret_address = 0;
    ib.rd_ret_ack = 0; ib.rd_ret_address = 0; ib.rd_ret_data = 0;
    ib.wr_ret_ack = 0; ib.wr_ret_address = 0;
    repeat (3) cyc();

    // reset state
    chk("rst_cmd_ready", ia.cmd_ready, 0);
    chk("rst_outstanding", ia.outstanding, 0);
    chk("rst_rd_en", ia.rd_en, 0);
    chk("rst_errs", {ia.err_unexpected, ia.err_timeout, ib.err_unexpected, ib.err_timeout}, 0);
    rst_n = 1'b1;
    settle();
    chk("release_ready_low", ia.cmd_ready, 0);
    cyc();
    chk("release_ready_high", ia.cmd_ready, 1);

    // single read round trip
    a_cmd(1, 0, 16'h0010, 16'h0);
    settle();
    chk("rd10_ready", ia.cmd_ready, 1);
    cyc();
    a_cmd(0, 0, 16'h0, 16'h0);
    chk("rd10_rd_en", ia.rd_en, 1);
    chk("rd10_rd_address", ia.rd_address, 16'h0010);
    chk("rd10_outstanding", ia.outstanding, 1);
    cyc();
    chk("rd10_rd_en_once", ia.rd_en, 0);
    a_rret(1, 16'h0010, 16'hBEEF);
    cyc();
    a_rret(0, 16'h0, 16'h0);
    chk("rd10_outstanding_after", ia.outstanding, 0);

    // fill the table
    for (int i = 1; i <= 4; i++) begin
      a_cmd(1, 0, 16'(i), 16'h0);
      settle();
      chk("fill_ready", ia.cmd_ready, 1);
      cyc();
      chk("fill_rd_address", {15'h0, ia.rd_en, ia.rd_address}, {15'h0, 1'b1, 16'(i)});
    end
    chk("full_outstanding", ia.outstanding, 4);
    a_cmd(1, 0, 16'h0005, 16'h0);
    settle();
    chk("full_ready", ia.cmd_ready, 0);
    cyc();
    chk("full_no_issue", ia.rd_en, 0);
    a_rret(1, 16'h0002, 16'h2222);
    settle();
    chk("free_same_cycle_ready", ia.cmd_ready, 0);
    cyc();
    a_rret(0, 16'h0, 16'h0);
    chk("free_next_ready", ia.cmd_ready, 1);
    chk("free_outstanding", ia.outstanding, 3);
    cyc();
    a_cmd(0, 0, 16'h0, 16'h0);
    chk("refill_rd", {15'h0, ia.rd_en, ia.rd_address}, {15'h0, 1'b1, 16'h0005});
    chk("refill_outstanding", ia.outstanding, 4);

    // duplicate tag blocked while outstanding
    a_rret(1, 16'h0001, 16'h1111);
    cyc();
    a_rret(0, 16'h0, 16'h0);
    a_cmd(1, 0, 16'h0003, 16'h0);
    settle();
    chk("dup_ready", ia.cmd_ready, 0);
    cyc();
    chk("dup_no_issue", ia.rd_en, 0);
    a_rret(1, 16'h0003, 16'h3333);
    settle();
    chk("dup_ready_during_ret", ia.cmd_ready, 0);
    cyc();
    a_rret(0, 16'h0, 16'h0);
    chk("dup_ready_after_ret", ia.cmd_ready, 1);
    cyc();
    a_cmd(0, 0, 16'h0, 16'h0);
    chk("dup_issue", {15'h0, ia.rd_en, ia.rd_address}, {15'h0, 1'b1, 16'h0003});
    a_rret(1, 16'h0003, 16'h3030);
    cyc();
    a_rret(1, 16'h0004, 16'h4444);
    cyc();
    a_rret(1, 16'h0005, 16'h5555);
    cyc();
    a_rret(0, 16'h0, 16'h0);
    chk("drain_outstanding", ia.outstanding, 0);
    chk("drain_no_err", ia.err_unexpected, 0);

    // unexpected return on empty table (not pushed: no response allowed)
    ia.rd_ret_ack = 1; ia.rd_ret_address = 16'h7777; ia.rd_ret_data = 16'h0;
    cyc();
    ia.rd_ret_ack = 0;
    chk("unexp_set", ia.err_unexpected, 1);
    cyc();
    chk("unexp_sticky", ia.err_unexpected, 1);

    // posted write
    a_cmd(1, 1, 16'h0020, 16'h1234);
    qa_wr.push_back({16'h0020, 16'h0});
    settle();
    chk("wr_ready", ia.cmd_ready, 1);
    cyc();
    a_cmd(0, 0, 16'h0, 16'h0);
    chk("wr_strobe", {ia.wr_en, ia.wr_resp_valid}, 2'b11);
    chk("wr_addr_data", {ia.wr_address, ia.wr_data}, {16'h0020, 16'h1234});
    chk("wr_outstanding", ia.outstanding, 0);
    cyc();
    chk("wr_en_once", ia.wr_en, 0);

    // reset with two reads in flight
    a_cmd(1, 0, 16'h0030, 16'h0);
    cyc();
    a_cmd(1, 0, 16'h0031, 16'h0);
    cyc();
    a_cmd(0, 0, 16'h0, 16'h0);
    chk("pre_rst_outstanding", ia.outstanding, 2);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_status", {ia.cmd_ready, 3'(ia.outstanding), ia.err_unexpected, ia.err_timeout}, 0);
    chk("mid_rst_strobes", {ia.rd_en, ia.wr_en, ia.rd_resp_valid, ia.wr_resp_valid}, 0);
    chk("mid_rst_addr", {ia.rd_address, ia.wr_address}, 0);
    chk("mid_rst_data", {ia.wr_data, ia.rd_resp_data}, 0);
    rst_n = 1'b1;
    cyc();
    ia.rd_ret_ack = 1; ia.rd_ret_address = 16'h0030; ia.rd_ret_data = 16'hDEAD;
    cyc();
    ia.rd_ret_ack = 0;
    chk("post_rst_stale_ret", ia.err_unexpected, 1);

    // B: timeout of a lost read
    b_cmd(1, 0, 16'h0040, 16'h0);
    cyc();
    b_cmd(0, 0, 16'h0, 16'h0);
    chk("b_rd_issue", {15'h0, ib.rd_en, ib.rd_address}, {15'h0, 1'b1, 16'h0040});
    repeat (4) cyc();
    chk("b_pre_timeout", {30'h0, ib.outstanding, ib.err_timeout}, {30'h0, 2'd1, 1'b0});
    cyc();
    chk("b_timeout", {30'h0, ib.outstanding, ib.err_timeout}, {30'h0, 2'd0, 1'b1});

    // B: tracked write plus read, returned together
    b_cmd(1, 1, 16'h0050, 16'hAAAA);
    cyc();
    chk("b_wr_strobe", {ib.wr_en, ib.wr_resp_valid}, 2'b10);
    chk("b_wr_outstanding", ib.outstanding, 1);
    b_cmd(1, 0, 16'h0060, 16'h0);
    cyc();
    b_cmd(0, 0, 16'h0061, 16'h0);
    settle();
    chk("b_full_ready", ib.cmd_ready, 0);
    chk("b_full_outstanding", ib.outstanding, 2);
    ib.wr_ret_ack = 1; ib.wr_ret_address = 16'h0050;
    ib.rd_ret_ack = 1; ib.rd_ret_address = 16'h0060; ib.rd_ret_data = 16'hCAFE;
    qb_wr.push_back({16'h0050, 16'h0});
    qb_rd.push_back({16'h0060, 16'hCAFE});
    cyc();
    ib.wr_ret_ack = 0; ib.rd_ret_ack = 0;
    chk("b_dual_ret_outstanding", ib.outstanding, 0);
    chk("b_dual_ret_no_err", ib.err_unexpected, 0);

    // B: return arriving on the timeout cycle
    b_cmd(1, 0, 16'h0070, 16'h0);
    cyc();
    b_cmd(0, 0, 16'h0, 16'h0);
    repeat (4) cyc();
    ib.rd_ret_ack = 1; ib.rd_ret_address = 16'h0070; ib.rd_ret_data = 16'h7070;
    cyc();
    ib.rd_ret_ack = 0;
    chk("b_race_err", ib.err_unexpected, 1);
    chk("b_race_outstanding", ib.outstanding, 0);

    cyc();
    cyc();
    chk("sb_a_rd_empty", qa_rd.size(), 0);
    chk("sb_a_wr_empty", qa_wr.size(), 0);
    chk("sb_b_rd_empty", qb_rd.size(), 0);
    chk("sb_b_wr_empty", qb_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter DEPTH, default 4: outstanding-request table entries, 1..8.
REQ-002 SHALL have parameter TIMEOUT, default 200: cycles before an outstanding entry is declared lost, 1..255.
REQ-003 SHALL have parameter WR_ACK_EN, default 0: 1 = writes tracked until wr_ret_ack; 0 = writes posted.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clock edge.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_address  in  16  request address, also the tag.
REQ-011 cmd_data  in  16  write data.
REQ-012 wr_address / wr_data  out  16 / 16  write request to memory side.
REQ-013 wr_en  out  1  one-cycle write strobe.
REQ-014 wr_ret_address  in  16  write-return tag.
REQ-015 wr_ret_ack  in  1  write-return strobe.
REQ-016 rd_address  out  16  read request address.
REQ-017 rd_en  out  1  one-cycle read strobe.
REQ-018 rd_ret_address / rd_ret_data  in  16 / 16  read-return tag and data.
REQ-019 rd_ret_ack  in  1  read-return strobe.
REQ-020 rd_resp_valid / rd_resp_address / rd_resp_data  out  1 / 16 / 16  completed read to client.
REQ-021 wr_resp_valid / wr_resp_address  out  1 / 16  completed write to client.
REQ-022 outstanding  out  $clog2(DEPTH+1)  valid table entries.
REQ-023 err_unexpected / err_timeout  out  1 / 1  sticky error flags.

Function
REQ-024 Table entry SHALL hold {valid, is_write, address[15:0], age[7:0]}.
REQ-025 cmd_ready SHALL be combinational from registered state only: 1 when no reset, a free entry exists, and no valid entry holds cmd_address.
REQ-026 Accepted read SHALL allocate the lowest-index free entry (age 0) and drive rd_en=1, rd_address on the next cycle only.
REQ-027 Accepted write SHALL drive wr_en=1, wr_address, wr_data on the next cycle only; it allocates an entry only if WR_ACK_EN=1.
REQ-028 With WR_ACK_EN=0, wr_resp_valid SHALL pulse with wr_en in the same cycle; wr_ret_ack ignored.
REQ-029 Request latency SHALL be 1 cycle, accept to strobe; at most one request issued per cycle.
REQ-030 rd_ret_ack matching a valid read entry SHALL free it and, next cycle, pulse rd_resp_valid for 1 cycle with that address and rd_ret_data.
REQ-031 wr_ret_ack (WR_ACK_EN=1) matching a valid write entry SHALL free it and, next cycle, pulse wr_resp_valid with the address.
REQ-032 Return with no matching valid entry of its type SHALL set err_unexpected; table unchanged; no response.
REQ-033 Read and write returns in the same cycle SHALL both be processed.
REQ-034 A freed entry SHALL be allocatable no earlier than the following cycle; accept and free in one cycle both take effect.
REQ-035 Age SHALL increment each cycle per valid entry, saturating; reaching TIMEOUT SHALL free the entry, set err_timeout, no response.
REQ-036 A return in the same cycle as its entry's timeout SHALL be treated as a timeout and flag err_unexpected.
REQ-037 outstanding SHALL equal the count of valid entries and never exceed DEPTH.

Reset
REQ-038 rst_n=0 at a clock edge SHALL clear all entries, cmd_ready, all strobes/resp valids, address/data outputs, outstanding and both error flags to 0.
REQ-039 Reset mid-operation SHALL drop in-flight requests; later returns for them SHALL set err_unexpected.
REQ-040 cmd_ready SHALL be 0 while rst_n=0 and rise the first cycle after release.

Verification
REQ-041 Read 0x0010 accepted cycle N -> rd_en=1, rd_address=0x0010 at N+1; rd_ret_ack addr 0x0010 data 0xBEEF at M -> rd_resp_valid with 0x0010/0xBEEF at M+1; outstanding 1 then 0.
REQ-042 DEPTH=4: four reads 0x1..0x4, no returns -> cmd_ready=0, outstanding=4; return 0x2 -> cmd_ready=1 next cycle.
REQ-043 Second read 0x0010 while 0x0010 outstanding -> cmd_ready=0 until return consumed.
REQ-044 rd_ret_ack addr 0x7777 with empty table -> err_unexpected=1, stays 1, no rd_resp_valid.
REQ-045 TIMEOUT=5, read never returned -> entry freed and err_timeout=1 five cycles after allocation; outstanding=0.
REQ-046 WR_ACK_EN=0 write 0x0020/0x1234 -> wr_en, wr_resp_valid at N+1, outstanding stays 0; reset with 2 reads pending -> all outputs 0.
